// File: rtl/biq_pkg.sv
// biq_pkg: shared sizing, pointer/tag types and the queue entry record
package biq_pkg;
   localparam int DEPTH = 8;
   localparam int AW = 8;
   localparam int GHR_W = 5;
   localparam int TAG_W = 3;
   localparam int PW = TAG_W + 1;
   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [PW-1:0] ptr_t;
   typedef struct packed {
      logic valid;
      logic resolved;
      logic pred;
      logic taken;
      logic [AW-1:0] pc;
      logic [AW-1:0] fallthru;
      logic [AW-1:0] target;
      logic [GHR_W-1:0] ghr;
   } entry_t;
   // distance from the oldest entry; modulo arithmetic makes wrap-around free
   function automatic tag_t age_of(input tag_t tag, input tag_t head);
      return tag - head;
   endfunction
endpackage

// File: rtl/branch_info_queue_if.sv
// branch_info_queue_if: fetch allocation, execute resolution and BPU update/recovery bundle
interface branch_info_queue_if;
   import biq_pkg::*;
   logic alloc_valid1, alloc_valid2;
   logic [AW-1:0] alloc_pc1, alloc_pc2;
   logic [AW-1:0] alloc_fallthru1, alloc_fallthru2;
   logic [AW-1:0] alloc_target1, alloc_target2;
   logic alloc_pred1, alloc_pred2;
   logic [GHR_W-1:0] alloc_ghr;
   logic alloc_ready;
   logic [TAG_W-1:0] alloc_tag1, alloc_tag2;
   logic resolve_valid1, resolve_valid2;
   logic [TAG_W-1:0] resolve_tag1, resolve_tag2;
   logic resolve_taken1, resolve_taken2;
   logic update_signal1, update_signal2;
   logic actual_outcome1, actual_outcome2;
   logic [AW-1:0] branch_address_E1, branch_address_E2;
   logic [GHR_W-1:0] ghr_E1, ghr_E2;
   logic flush;
   logic [AW-1:0] redirect_pc;
   logic [GHR_W-1:0] restored_ghr;
   logic [TAG_W:0] count;
   modport master (
      output alloc_valid1, alloc_valid2, alloc_pc1, alloc_pc2, alloc_fallthru1, alloc_fallthru2,
             alloc_target1, alloc_target2, alloc_pred1, alloc_pred2, alloc_ghr,
             resolve_valid1, resolve_valid2, resolve_tag1, resolve_tag2, resolve_taken1, resolve_taken2,
      input  alloc_ready, alloc_tag1, alloc_tag2, update_signal1, update_signal2,
             actual_outcome1, actual_outcome2, branch_address_E1, branch_address_E2, ghr_E1, ghr_E2,
             flush, redirect_pc, restored_ghr, count
   );
   modport slave (
      input  alloc_valid1, alloc_valid2, alloc_pc1, alloc_pc2, alloc_fallthru1, alloc_fallthru2,
             alloc_target1, alloc_target2, alloc_pred1, alloc_pred2, alloc_ghr,
             resolve_valid1, resolve_valid2, resolve_tag1, resolve_tag2, resolve_taken1, resolve_taken2,
      output alloc_ready, alloc_tag1, alloc_tag2, update_signal1, update_signal2,
             actual_outcome1, actual_outcome2, branch_address_E1, branch_address_E2, ghr_E1, ghr_E2,
             flush, redirect_pc, restored_ghr, count
   );
endinterface

// File: rtl/biq_age_sel.sv
// biq_age_sel: picks the older of two mispredict candidates relative to the queue head
module biq_age_sel
   import biq_pkg::*;
(
   input  tag_t head,
   input  logic v1,
   input  tag_t tag1,
   input  logic v2,
   input  tag_t tag2,
   output logic win_valid,
   output logic win_sel,
   output tag_t win_tag,
   output tag_t win_age
);
   tag_t age1, age2;
   always_comb begin
      age1 = age_of(tag1, head);
      age2 = age_of(tag2, head);
      win_valid = v1 || v2;
      win_sel = v2 && (!v1 || age2 < age1);
      win_tag = win_sel ? tag2 : tag1;
      win_age = win_sel ? age2 : age1;
   end
endmodule

// File: rtl/branch_info_queue.sv
// branch_info_queue: tracks predicted branches from fetch to retirement,
// repairs fetch on mispredict and feeds retired outcomes back to the PHT
module branch_info_queue
   import biq_pkg::*;
(
   input logic clk,
   input logic rst,
   branch_info_queue_if.slave bus
);
   entry_t ent_q [DEPTH];
   entry_t ent_d [DEPTH];
   entry_t ew;
   ptr_t head_q, head_d, tail_q, tail_d, cnt;
   tag_t h, h1, tag1, tag2, rt1, rt2, win_tag, win_age;
   logic ready, ok1, ok2, mp1, mp2, mp, win_sel, taken_w, ret0, ret1;
   logic us1_q, us1_d, us2_q, us2_d, ao1_q, ao1_d, ao2_q, ao2_d, flush_q, flush_d;
   logic [AW-1:0] ba1_q, ba1_d, ba2_q, ba2_d, rpc_q, rpc_d;
   logic [GHR_W-1:0] ge1_q, ge1_d, ge2_q, ge2_d, rghr_q, rghr_d;
   always_comb begin
      h = head_q[TAG_W-1:0];
      h1 = h + tag_t'(1);
      cnt = tail_q - head_q;
      ready = cnt <= ptr_t'(DEPTH - 2);
      tag1 = tail_q[TAG_W-1:0];
      tag2 = tag1 + tag_t'(bus.alloc_valid1);
      rt1 = bus.resolve_tag1;
      rt2 = bus.resolve_tag2;
      ok1 = bus.resolve_valid1 && ent_q[rt1].valid && !ent_q[rt1].resolved;
      ok2 = bus.resolve_valid2 && ent_q[rt2].valid && !ent_q[rt2].resolved;
      mp1 = ok1 && (bus.resolve_taken1 != ent_q[rt1].pred);
      mp2 = ok2 && (bus.resolve_taken2 != ent_q[rt2].pred);
   end
   biq_age_sel u_age_sel (
      .head(h), .v1(mp1), .tag1(rt1), .v2(mp2), .tag2(rt2),
      .win_valid(mp), .win_sel(win_sel), .win_tag(win_tag), .win_age(win_age)
   );
   always_comb begin
      ent_d = ent_q;
      ew = ent_q[win_tag];
      taken_w = win_sel ? bus.resolve_taken2 : bus.resolve_taken1;
      ret0 = ent_q[h].valid && ent_q[h].resolved;
      ret1 = ret0 && ent_q[h1].valid && ent_q[h1].resolved;
      head_d = head_q + ptr_t'(ret0) + ptr_t'(ret1);
      tail_d = tail_q;
      if (ret0) ent_d[h].valid = 1'b0;
      if (ret1) ent_d[h1].valid = 1'b0;
      // a resolve younger than the winning mispredict belongs to a squashed path
      if (ok1 && !(mp && age_of(rt1, h) > win_age)) begin
         ent_d[rt1].resolved = 1'b1;
         ent_d[rt1].taken = bus.resolve_taken1;
      end
      if (ok2 && !(mp && age_of(rt2, h) > win_age)) begin
         ent_d[rt2].resolved = 1'b1;
         ent_d[rt2].taken = bus.resolve_taken2;
      end
      if (mp) begin
         tail_d = head_q + ptr_t'(win_age) + ptr_t'(1);
         for (int j = 0; j < DEPTH; j++)
            if (age_of(tag_t'(j), h) > win_age) ent_d[j].valid = 1'b0;
      end else if (ready) begin
         if (bus.alloc_valid1)
            ent_d[tag1] = '{1'b1, 1'b0, bus.alloc_pred1, 1'b0, bus.alloc_pc1,
                            bus.alloc_fallthru1, bus.alloc_target1, bus.alloc_ghr};
         if (bus.alloc_valid2)
            ent_d[tag2] = '{1'b1, 1'b0, bus.alloc_pred2, 1'b0, bus.alloc_pc2,
                            bus.alloc_fallthru2, bus.alloc_target2,
                            bus.alloc_valid1 ? {bus.alloc_ghr[GHR_W-2:0], bus.alloc_pred1} : bus.alloc_ghr};
         tail_d = tail_q + ptr_t'(bus.alloc_valid1) + ptr_t'(bus.alloc_valid2);
      end
      us1_d = ret0;
      us2_d = ret1;
      ao1_d = ret0 && ent_q[h].taken;
      ao2_d = ret1 && ent_q[h1].taken;
      ba1_d = ret0 ? ent_q[h].pc : '0;
      ba2_d = ret1 ? ent_q[h1].pc : '0;
      ge1_d = ret0 ? ent_q[h].ghr : '0;
      ge2_d = ret1 ? ent_q[h1].ghr : '0;
      flush_d = mp;
      rpc_d = mp ? (taken_w ? ew.target : ew.fallthru) : '0;
      rghr_d = mp ? {ew.ghr[GHR_W-2:0], taken_w} : '0;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int j = 0; j < DEPTH; j++) ent_q[j] <= '0;
         head_q <= '0;
         tail_q <= '0;
         {us1_q, us2_q, ao1_q, ao2_q, flush_q} <= '0;
         {ba1_q, ba2_q, rpc_q} <= '0;
         {ge1_q, ge2_q, rghr_q} <= '0;
      end else begin
         ent_q <= ent_d;
         head_q <= head_d;
         tail_q <= tail_d;
         {us1_q, us2_q, ao1_q, ao2_q, flush_q} <= {us1_d, us2_d, ao1_d, ao2_d, flush_d};
         {ba1_q, ba2_q, rpc_q} <= {ba1_d, ba2_d, rpc_d};
         {ge1_q, ge2_q, rghr_q} <= {ge1_d, ge2_d, rghr_d};
      end
   end
   assign bus.alloc_ready = ready;
   assign bus.alloc_tag1 = tag1;
   assign bus.alloc_tag2 = tag2;
   assign bus.count = cnt;
   assign bus.update_signal1 = us1_q;
   assign bus.update_signal2 = us2_q;
   assign bus.actual_outcome1 = ao1_q;
   assign bus.actual_outcome2 = ao2_q;
   assign bus.branch_address_E1 = ba1_q;
   assign bus.branch_address_E2 = ba2_q;
   assign bus.ghr_E1 = ge1_q;
   assign bus.ghr_E2 = ge2_q;
   assign bus.flush = flush_q;
   assign bus.redirect_pc = rpc_q;
   assign bus.restored_ghr = rghr_q;
endmodule

// File: tb/tb_branch_info_queue.sv
// tb_branch_info_queue: directed cycle-by-cycle vectors with hand-computed expectations,
// plus a reset-during-recovery sequence
module tb_branch_info_queue;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int n_cmp = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   branch_info_queue_if bus ();
   branch_info_queue dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic a1, a2;
      logic [7:0] p1, p2;
      logic pr1, pr2;
      logic [4:0] gh;
      logic r1, r2;
      logic [2:0] rt1, rt2;
      logic rk1, rk2;
      logic tchk;
      logic [2:0] et1, et2;
      logic [3:0] ecnt;
      logic erdy, efl;
      logic [7:0] erpc;
      logic [4:0] erg;
      logic eu1, eu2;
      logic [7:0] eb1, eb2;
      logic [4:0] eg1, eg2;
      logic eo1, eo2;
   } vec_t;
   localparam int NV = 24;
   vec_t v [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic vin(input int i, input logic a1, a2, input logic [7:0] p1, p2, input logic pr1, pr2,
                      input logic [4:0] gh, input logic r1, r2, input logic [2:0] rt1, rt2, input logic rk1, rk2);
      v[i].a1 = a1; v[i].a2 = a2; v[i].p1 = p1; v[i].p2 = p2; v[i].pr1 = pr1; v[i].pr2 = pr2; v[i].gh = gh;
      v[i].r1 = r1; v[i].r2 = r2; v[i].rt1 = rt1; v[i].rt2 = rt2; v[i].rk1 = rk1; v[i].rk2 = rk2;
   endtask

   task automatic vex(input int i, input logic tchk, input logic [2:0] et1, et2, input logic [3:0] ecnt,
                      input logic erdy, efl, input logic [7:0] erpc, input logic [4:0] erg);
      v[i].tchk = tchk; v[i].et1 = et1; v[i].et2 = et2; v[i].ecnt = ecnt;
      v[i].erdy = erdy; v[i].efl = efl; v[i].erpc = erpc; v[i].erg = erg;
   endtask

   task automatic vup(input int i, input logic u1, u2, input logic [7:0] b1, b2, input logic [4:0] g1, g2,
                      input logic o1, o2);
      v[i].eu1 = u1; v[i].eu2 = u2; v[i].eb1 = b1; v[i].eb2 = b2;
      v[i].eg1 = g1; v[i].eg2 = g2; v[i].eo1 = o1; v[i].eo2 = o2;
   endtask

   task automatic drive(input vec_t x);
      bus.alloc_valid1 = x.a1; bus.alloc_valid2 = x.a2;
      bus.alloc_pc1 = x.p1; bus.alloc_pc2 = x.p2;
      bus.alloc_fallthru1 = x.p1 + 8'h04; bus.alloc_fallthru2 = x.p2 + 8'h04;
      bus.alloc_target1 = x.p1 + 8'h40; bus.alloc_target2 = x.p2 + 8'h40;
      bus.alloc_pred1 = x.pr1; bus.alloc_pred2 = x.pr2; bus.alloc_ghr = x.gh;
      bus.resolve_valid1 = x.r1; bus.resolve_valid2 = x.r2;
      bus.resolve_tag1 = x.rt1; bus.resolve_tag2 = x.rt2;
      bus.resolve_taken1 = x.rk1; bus.resolve_taken2 = x.rk2;
   endtask

   task automatic chk_zero(input string ph);
      chk({ph, " count"}, 32'(bus.count), 0);
      chk({ph, " alloc_ready"}, 32'(bus.alloc_ready), 1);
      chk({ph, " flush"}, 32'(bus.flush), 0);
      chk({ph, " redirect_pc"}, 32'(bus.redirect_pc), 0);
      chk({ph, " restored_ghr"}, 32'(bus.restored_ghr), 0);
      chk({ph, " update1"}, 32'(bus.update_signal1), 0);
      chk({ph, " update2"}, 32'(bus.update_signal2), 0);
      chk({ph, " outcome1"}, 32'(bus.actual_outcome1), 0);
      chk({ph, " addr1"}, 32'(bus.branch_address_E1), 0);
      chk({ph, " ghrE1"}, 32'(bus.ghr_E1), 0);
      chk({ph, " tag1"}, 32'(bus.alloc_tag1), 0);
   endtask

   initial begin
      for (int i = 0; i < NV; i++) v[i] = '0;
      vin(0, 1,1, 8'h10,8'h14, 1,0, 5'b00110, 0,0,0,0,0,0);  vex(0, 1,0,1, 2,1,0,0,0);
      vin(1, 0,0, 0,0, 0,0, 0, 1,1,0,1,1,0);                  vex(1, 0,0,0, 2,1,0,0,0);
      vex(2, 0,0,0, 0,1,0,0,0);  vup(2, 1,1, 8'h10,8'h14, 5'b00110,5'b01101, 1,0);
      vex(3, 0,0,0, 0,1,0,0,0);
      vin(4, 1,1, 8'h1C,8'h20, 0,1, 5'b00011, 0,0,0,0,0,0);  vex(4, 1,2,3, 2,1,0,0,0);
      vin(5, 1,1, 8'h28,8'h2C, 1,1, 5'b01010, 0,0,0,0,0,0);  vex(5, 1,4,5, 4,1,0,0,0);
      vin(6, 1,1, 8'h30,8'h34, 0,0, 5'b00001, 0,0,0,0,0,0);  vex(6, 1,6,7, 6,1,0,0,0);
      vin(7, 1,1, 8'h40,8'h44, 0,0, 0, 1,0,3,0,0,0);          vex(7, 0,0,0, 2,1,1,8'h24,5'b01100);
      vin(8, 0,0, 0,0, 0,0, 0, 1,0,4,0,1,0);                  vex(8, 0,0,0, 2,1,0,0,0);
      vin(9, 0,0, 0,0, 0,0, 0, 1,0,2,0,0,0);                  vex(9, 0,0,0, 2,1,0,0,0);
      vex(10, 0,0,0, 0,1,0,0,0); vup(10, 1,1, 8'h1C,8'h20, 5'b00011,5'b00110, 0,0);
      vin(11, 1,1, 8'h50,8'h54, 1,1, 5'b10000, 0,0,0,0,0,0); vex(11, 1,4,5, 2,1,0,0,0);
      vin(12, 1,1, 8'h58,8'h5C, 0,1, 5'b01111, 0,0,0,0,0,0); vex(12, 1,6,7, 4,1,0,0,0);
      vin(13, 1,1, 8'h60,8'h64, 1,0, 5'b00101, 0,0,0,0,0,0); vex(13, 1,0,1, 6,1,0,0,0);
      vin(14, 0,0, 0,0, 0,0, 0, 1,1,1,6,1,1);                 vex(14, 0,0,0, 3,1,1,8'h98,5'b11111);
      vex(15, 0,0,0, 3,1,0,0,0);
      vin(16, 1,0, 8'h70,0, 0,0, 0, 0,0,0,0,0,0);             vex(16, 1,7,0, 4,1,0,0,0);
      vin(17, 1,1, 8'h74,8'h78, 0,0, 0, 0,0,0,0,0,0);         vex(17, 1,0,1, 6,1,0,0,0);
      vin(18, 0,1, 0,8'h7C, 0,1, 5'b00010, 0,0,0,0,0,0);      vex(18, 1,0,2, 7,0,0,0,0);
      vin(19, 1,1, 8'h80,8'h84, 0,0, 0, 0,0,0,0,0,0);         vex(19, 1,3,4, 7,0,0,0,0);
      vin(20, 1,1, 8'h80,8'h84, 0,0, 0, 1,1,4,5,1,1);         vex(20, 0,0,0, 7,0,0,0,0);
      vex(21, 0,0,0, 5,1,0,0,0); vup(21, 1,1, 8'h50,8'h54, 5'b10000,5'b00001, 1,1);
      vex(22, 0,0,0, 4,1,0,0,0); vup(22, 1,0, 8'h58,0, 5'b01111,0, 1,0);
      vin(23, 1,1, 8'h90,8'h94, 0,0, 0, 0,0,0,0,0,0);         vex(23, 1,3,4, 6,1,0,0,0);

      drive('0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(v[i]);
         #1;
         if (v[i].tchk && v[i].a1) chk($sformatf("v%0d alloc_tag1", i), 32'(bus.alloc_tag1), 32'(v[i].et1));
         if (v[i].tchk && v[i].a2) chk($sformatf("v%0d alloc_tag2", i), 32'(bus.alloc_tag2), 32'(v[i].et2));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d count", i), 32'(bus.count), 32'(v[i].ecnt));
         chk($sformatf("v%0d alloc_ready", i), 32'(bus.alloc_ready), 32'(v[i].erdy));
         chk($sformatf("v%0d flush", i), 32'(bus.flush), 32'(v[i].efl));
         chk($sformatf("v%0d update1", i), 32'(bus.update_signal1), 32'(v[i].eu1));
         chk($sformatf("v%0d update2", i), 32'(bus.update_signal2), 32'(v[i].eu2));
         if (v[i].efl) begin
            chk($sformatf("v%0d redirect_pc", i), 32'(bus.redirect_pc), 32'(v[i].erpc));
            chk($sformatf("v%0d restored_ghr", i), 32'(bus.restored_ghr), 32'(v[i].erg));
         end
         if (v[i].eu1) begin
            chk($sformatf("v%0d addr1", i), 32'(bus.branch_address_E1), 32'(v[i].eb1));
            chk($sformatf("v%0d ghrE1", i), 32'(bus.ghr_E1), 32'(v[i].eg1));
            chk($sformatf("v%0d outcome1", i), 32'(bus.actual_outcome1), 32'(v[i].eo1));
         end
         if (v[i].eu2) begin
            chk($sformatf("v%0d addr2", i), 32'(bus.branch_address_E2), 32'(v[i].eb2));
            chk($sformatf("v%0d ghrE2", i), 32'(bus.ghr_E2), 32'(v[i].eg2));
            chk($sformatf("v%0d outcome2", i), 32'(bus.actual_outcome2), 32'(v[i].eo2));
         end
      end

      // head tag7 resolved, then reset lands together with a mispredict and a pending retire
      drive('0);
      bus.resolve_valid1 = 1'b1; bus.resolve_tag1 = 3'd7; bus.resolve_taken1 = 1'b0;
      @(posedge clk);
      #1;
      chk("pre-reset count", 32'(bus.count), 6);
      chk("pre-reset flush", 32'(bus.flush), 0);
      drive('0);
      bus.resolve_valid1 = 1'b1; bus.resolve_tag1 = 3'd0; bus.resolve_taken1 = 1'b1;
      bus.alloc_valid1 = 1'b1; bus.alloc_valid2 = 1'b1; bus.alloc_pc1 = 8'hB0; bus.alloc_pc2 = 8'hB4;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_zero("mid-reset");
      chk("mid-reset update2", 32'(bus.update_signal2), 0);
      drive('0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset flush", 32'(bus.flush), 0);
      chk("post-reset update1", 32'(bus.update_signal1), 0);
      chk("post-reset count", 32'(bus.count), 0);
      bus.alloc_valid1 = 1'b1; bus.alloc_valid2 = 1'b1; bus.alloc_pc1 = 8'hA0; bus.alloc_pc2 = 8'hA4;
      #1;
      chk("post-reset alloc_tag1", 32'(bus.alloc_tag1), 0);
      chk("post-reset alloc_tag2", 32'(bus.alloc_tag2), 1);
      @(posedge clk);
      #1;
      chk("post-reset alloc count", 32'(bus.count), 2);
      drive('0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
